mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates a single byte-wide synchronous RAM between the instruction-fetch (IF) port and the load/store (MEM) port of the pipeline.
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or splits little-endian words.
- Returns one done pulse per transaction; upstream stages stall on their own req until done.

Parameters:
- ADDR_W, 17, RAM address width; all address arithmetic wraps modulo 2^ADDR_W.
- MEM_FIRST, 1, 1 = MEM port wins simultaneous requests; 0 = IF wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  32  fetch byte address; low ADDR_W bits used.
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word.
- mem_req  in  1  load/store request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  00 = byte, 01 = half, 11 = word; 10 is treated as word.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data; low N bytes used.
- mem_done  out  1  one-cycle pulse.
- mem_rdata  out  32  load data, zero-extended; sign extension is done by the MEM stage.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM byte write enable.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid one cycle after its address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - All outputs 0: if_done, mem_done, ram_we, busy, ram_addr, ram_dout, if_data, mem_rdata.
  - Byte counter and data register cleared.
- FSM: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - At a clock edge with any req high, latch owner, address, len, we and wdata.
  - Go to XFER with cnt = 0.
  - Both reqs high: owner is MEM if MEM_FIRST = 1, else IF.
  - IF is always a read with N = 4.
- XFER, issue and capture:
  - ram_addr = base + cnt (wraps at 2^ADDR_W).
  - Read: byte k is issued in XFER cycle k and captured from ram_din at the next edge into bits [8k+7:8k].
  - Write: ram_we = 1 and ram_dout = wdata[8cnt+7:8cnt] during cycles cnt = 0..N-1; ram_we is 0 in every other state.
- XFER, timing:
  - Read occupies N+1 XFER cycles; the last cycle only captures.
  - Write occupies N XFER cycles.
  - Read done pulse appears N+2 cycles after the sampling edge; write done pulse appears N+1 cycles after it.
- DONE:
  - Exactly one cycle; the owner's done = 1 and its data output is valid.
  - No request is sampled in DONE, so a requester may drop req combinationally on done.
  - The next transaction can start at the edge leaving IDLE, i.e. minimum 1 idle cycle between transactions.
- Data outputs:
  - if_data and mem_rdata hold their last value until the next completion of the same port.
  - Unread upper bytes of mem_rdata are 0.
- Protocol rules:
  - Requests are not cancellable.
  - Changes to addr/len/wdata after the sampling edge are ignored.
  - A req dropped mid-transfer does not abort the transfer.
- Reset mid-transfer: immediate return to IDLE; ram_we drops asynchronously; a partial write stays in RAM; no done is generated.
- Fairness: fixed priority, with no starvation guarantee. The pipeline guarantees that IF and MEM are never both continuously requesting.

Decomposition:
- Shared package mem_pkg holds:
  - the len encoding constants LEN_B, LEN_H, LEN_W;
  - the state enum {IDLE, XFER, DONE};
  - the function len_to_n() returning 1/2/4.
- One natural sub-module, mem_lane: byte-lane insert/extract (write byte select by cnt, read byte merge into the 32-bit register). The FSM and arbitration stay in mem_ctrl.

Test Plan:
- IF read: if_addr = 0x100, RAM[0x100..0x103] = 11 22 33 44 -> ram_addr steps 0x100..0x103, if_done one pulse 6 cycles after the sampling edge, if_data = 0x44332211, ram_we never high.
- MEM half store: mem_addr = 0x2, mem_len = 01, mem_wdata = 0x1234BEEF -> RAM[2] = 0xEF, RAM[3] = 0xBE, RAM[4] unchanged, mem_done 3 cycles after the sampling edge.
- MEM byte load: RAM[0x7] = 0x80, mem_len = 00 -> mem_rdata = 0x00000080, mem_done 3 cycles after the sampling edge.
- Simultaneous requests: if_req and mem_req high at the same edge, MEM_FIRST = 1 -> MEM transaction completes first; IF starts after DONE + IDLE; if_data correct. Repeat with MEM_FIRST = 0 -> IF first.
- Wrap-around: word load at address 2^ADDR_W-2 -> bytes read from 0x1FFFE, 0x1FFFF, 0x0, 0x1 and assembled in order.
- Reset mid-transfer: assert rst low during cnt = 1 of a word store -> ram_we = 0 immediately, busy = 0, no mem_done; only RAM[base] written. After release, a new IF read completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-serial RAM controller.
package mem_pkg;

    // Access-length encodings on mem_len; 2'b10 behaves like LEN_W.
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bytes moved for a given length code.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: picks the store byte for the current RAM cycle and
// merges a returning read byte into the little-endian word accumulator.
module mem_lane (
    input  logic [31:0] wdata_i,
    input  logic [1:0]  wsel_i,
    output logic [7:0]  wbyte_o,
    input  logic [31:0] acc_i,
    input  logic [1:0]  rsel_i,
    input  logic [7:0]  din_i,
    output logic [31:0] acc_o
);

    // Select store byte wsel_i of the latched write word.
    always_comb begin
        wbyte_o = wdata_i[{wsel_i, 3'b000} +: 8];
    end

    // Replace byte rsel_i of the accumulator with the RAM read byte.
    always_comb begin
        // NOTE: full default first so every path assigns acc_o; no latch is inferred.
        acc_o = acc_i;
        acc_o[{rsel_i, 3'b000} +: 8] = din_i;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between the fetch (IF) and
// load/store (MEM) ports, serialising 1/2/4-byte accesses into byte cycles.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter bit MEM_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic              owner_mem_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;
    logic              if_done_q;
    logic              mem_done_q;

    logic              grant_mem_d;
    logic [1:0]        rsel_d;
    logic [7:0]        wbyte_d;
    logic [31:0]       data_d;

    // Fixed-priority grant used only when sampling in IDLE.
    assign grant_mem_d = mem_req && (MEM_FIRST || !if_req);

    // Read byte k arrives one cycle after its address, i.e. while cnt = k+1.
    assign rsel_d = 2'(cnt_q - 3'd1);

    mem_lane u_lane (
        .wdata_i (wdata_q),
        .wsel_i  (cnt_q[1:0]),
        .wbyte_o (wbyte_d),
        .acc_i   (data_q),
        .rsel_i  (rsel_d),
        .din_i   (ram_din),
        .acc_o   (data_d)
    );

    // RAM-side outputs decoded from state so a reset removes ram_we at once.
    // NOTE: decoding ram_we from async-reset state (not registering it) makes it drop immediately on reset.
    always_comb begin
        busy     = (state_q != IDLE);
        ram_we   = (state_q == XFER) && we_q && (cnt_q < n_q);
        ram_addr = (state_q == XFER) ? base_q + ADDR_W'(cnt_q) : '0;
        ram_dout = ram_we ? wbyte_d : 8'h00;
    end

    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

    // Transaction FSM: sample and arbitrate, step byte cycles, pulse done.
    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            data_q      <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || mem_req) begin
                        state_q <= XFER;
                        cnt_q   <= 3'd0;
                        data_q  <= 32'h0;
                        if (grant_mem_d) begin
                            owner_mem_q <= 1'b1;
                            base_q      <= mem_addr[ADDR_W-1:0];
                            we_q        <= mem_we;
                            n_q         <= len_to_n(mem_len);
                            wdata_q     <= mem_wdata;
                        end else begin
                            owner_mem_q <= 1'b0;
                            base_q      <= if_addr[ADDR_W-1:0];
                            we_q        <= 1'b0;
                            n_q         <= 3'd4;
                            wdata_q     <= 32'h0;
                        end
                    end
                end
                XFER: begin
                    if (we_q) begin
                        if (cnt_q == n_q - 3'd1) begin
                            state_q    <= DONE;
                            mem_done_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            data_q <= data_d;
                        end
                        if (cnt_q == n_q) begin
                            state_q <= DONE;
                            if (owner_mem_q) begin
                                mem_done_q  <= 1'b1;
                                mem_rdata_q <= data_d;
                            end else begin
                                if_done_q <= 1'b1;
                                if_data_q <= data_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions, compared against a byte-array model of the RAM.
module tb_mem_ctrl;

    localparam int ADDR_W = 17;
    localparam int RAM_SZ = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // DUT a: MEM_FIRST = 1
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_len = 2'b00;
    logic [31:0]       mem_addr = 32'h0;
    logic [31:0]       mem_wdata = 32'h0;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              busy;

    // DUT b: MEM_FIRST = 0
    logic              b_if_req = 1'b0;
    logic [31:0]       b_if_addr = 32'h0;
    logic              b_if_done;
    logic [31:0]       b_if_data;
    logic              b_mem_req = 1'b0;
    logic [1:0]        b_mem_len = 2'b00;
    logic [31:0]       b_mem_addr = 32'h0;
    logic              b_mem_done;
    logic [31:0]       b_mem_rdata;
    logic [ADDR_W-1:0] b_ram_addr;
    logic              b_ram_we;
    logic [7:0]        b_ram_dout;
    logic [7:0]        b_ram_din;
    logic              b_busy;

    logic [7:0] ram     [RAM_SZ];
    logic [7:0] ram_b   [RAM_SZ];
    logic [7:0] ref_mem [RAM_SZ];
    logic       ram_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_if_data  = 32'h0;
    logic [31:0] exp_mem_data = 32'h0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W), .MEM_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy)
    );

    mem_ctrl #(.ADDR_W(ADDR_W), .MEM_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_data(b_if_data),
        .mem_req(b_mem_req), .mem_we(1'b0), .mem_len(b_mem_len), .mem_addr(b_mem_addr),
        .mem_wdata(32'h0), .mem_done(b_mem_done), .mem_rdata(b_mem_rdata),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_dout(b_ram_dout), .ram_din(b_ram_din),
        .busy(b_busy)
    );

    // Synchronous byte RAMs (read data one cycle after address); filled once with identical random bytes.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < RAM_SZ; i++) begin
                logic [7:0] v;
                v = 8'($urandom);
                ram[i]   <= v;
                ram_b[i] <= v;
            end
            ram_ready <= 1'b1;
        end else begin
            if (ram_we)   ram[ram_addr]     <= ram_dout;
            if (b_ram_we) ram_b[b_ram_addr] <= b_ram_dout;
        end
        ram_din   <= ram[ram_addr];
        b_ram_din <= ram_b[b_ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int len_n(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap(input logic [31:0] addr, input int k);
        return ADDR_W'(addr + 32'(k));
    endfunction

    function automatic logic [31:0] read_ref(input logic [31:0] addr, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < n; k++) w = w | (32'(ref_mem[wrap(addr, k)]) << (8 * k));
        return w;
    endfunction

    task automatic write_ref(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        for (int k = 0; k < n; k++) ref_mem[wrap(addr, k)] = wdata[8*k +: 8];
    endtask

    // One transaction on a single port of DUT a, checked cycle by cycle.
    task automatic txn(input bit is_mem, input bit we_in, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
        int n, lat, exp_lat;
        bit eff_we, done;
        logic [31:0] exp_data, got;
        n       = is_mem ? len_n(len) : 4;
        eff_we  = is_mem && we_in;
        exp_lat = eff_we ? n + 1 : n + 2;
        exp_data = eff_we ? 32'h0 : read_ref(addr, n);
        lat = 0;
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = eff_we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_in_xfer", 32'(busy), 32'd1);
                // Post-sampling changes must be ignored.
                mem_addr = $urandom; mem_wdata = $urandom; mem_len = 2'($urandom); if_addr = $urandom;
            end
            if (cyc <= n) begin
                check("ram_addr", 32'(ram_addr), 32'(wrap(addr, cyc - 1)));
                check("ram_we", 32'(ram_we), 32'(eff_we));
                if (eff_we) check("ram_dout", 32'(ram_dout), 32'(wdata[8*(cyc-1) +: 8]));
            end
            done = is_mem ? mem_done : if_done;
            if (done) begin
                lat = cyc;
                got = is_mem ? mem_rdata : if_data;
                if (!eff_we) check(is_mem ? "mem_rdata" : "if_data", got, exp_data);
                if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
                break;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        check("done_latency", 32'(lat), 32'(exp_lat));
        if (!eff_we) begin
            if (is_mem) exp_mem_data = exp_data; else exp_if_data = exp_data;
        end
        @(negedge clk);
        check("done_single_pulse", 32'(mem_done | if_done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("if_data_hold", if_data, exp_if_data);
        check("mem_rdata_hold", mem_rdata, exp_mem_data);
        if (eff_we) begin
            write_ref(addr, n, wdata);
            for (int k = 0; k <= n; k++)
                check("ram_content", 32'(ram[wrap(addr, k)]), 32'(ref_mem[wrap(addr, k)]));
        end
    endtask

    // Simultaneous requests on DUT a (MEM wins).
    task automatic both_a(input logic [31:0] maddr, input bit mwe, input logic [1:0] mlen,
                          input logic [31:0] mwdata, input logic [31:0] iaddr);
        int nm, tm, ti;
        logic [31:0] exp_m, exp_i;
        nm    = len_n(mlen);
        exp_m = mwe ? exp_mem_data : read_ref(maddr, nm);
        if (mwe) write_ref(maddr, nm, mwdata);
        exp_i = read_ref(iaddr, 4);
        tm = 0; ti = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = mwe; mem_len = mlen; mem_addr = maddr; mem_wdata = mwdata;
        if_req = 1'b1; if_addr = iaddr;
        for (int cyc = 1; cyc <= 40 && (mem_req || if_req); cyc++) begin
            @(negedge clk);
            if (mem_done && tm == 0) begin tm = cyc; mem_req = 1'b0; end
            if (if_done && ti == 0)  begin ti = cyc; if_req = 1'b0; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        check("a_mem_first_latency", 32'(tm), 32'(nm + (mwe ? 1 : 2)));
        check("a_if_second_latency", 32'(ti), 32'(nm + (mwe ? 1 : 2) + 7));
        check("a_both_mem_rdata", mem_rdata, exp_m);
        check("a_both_if_data", if_data, exp_i);
        exp_mem_data = exp_m; exp_if_data = exp_i;
        @(negedge clk);
    endtask

    // Simultaneous read requests on DUT b (IF wins).
    task automatic both_b(input logic [31:0] maddr, input logic [1:0] mlen, input logic [31:0] iaddr);
        int nm, tm, ti;
        nm = len_n(mlen);
        tm = 0; ti = 0;
        @(negedge clk);
        b_mem_req = 1'b1; b_mem_len = mlen; b_mem_addr = maddr;
        b_if_req = 1'b1; b_if_addr = iaddr;
        for (int cyc = 1; cyc <= 40 && (b_mem_req || b_if_req); cyc++) begin
            @(negedge clk);
            if (b_mem_done && tm == 0) begin tm = cyc; b_mem_req = 1'b0; end
            if (b_if_done && ti == 0)  begin ti = cyc; b_if_req = 1'b0; end
        end
        b_mem_req = 1'b0; b_if_req = 1'b0;
        check("b_if_first_latency", 32'(ti), 32'd6);
        check("b_mem_second_latency", 32'(tm), 32'(6 + 1 + nm + 2));
        check("b_both_if_data", b_if_data, read_ref(iaddr, 4));
        check("b_both_mem_rdata", b_mem_rdata, read_ref(maddr, nm));
        @(negedge clk);
    endtask

    // Reset asserted during cnt = 1 of a word store.
    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wdata);
        bit any_done;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = addr; mem_wdata = wdata;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_ram_we", 32'(ram_we), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_ram_we_async", 32'(ram_we), 32'd0);
        check("rst_busy_async", 32'(busy), 32'd0);
        check("rst_mem_done", 32'(mem_done), 32'd0);
        mem_req = 1'b0;
        ref_mem[wrap(addr, 0)] = wdata[7:0];
        exp_if_data = 32'h0; exp_mem_data = 32'h0;
        @(negedge clk);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        rst = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_done = any_done | mem_done | if_done;
        end
        check("rst_no_done", 32'(any_done), 32'd0);
        for (int k = 0; k < 4; k++)
            check("rst_partial_write", 32'(ram[wrap(addr, k)]), 32'(ref_mem[wrap(addr, k)]));
    endtask

    initial begin
        wait (ram_ready);
        @(negedge clk);
        for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = ram[i];

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'h0);
        check("reset_ram_dout", 32'(ram_dout), 32'h0);
        check("reset_dones", 32'({if_done, mem_done}), 32'd0);
        check("reset_if_data", if_data, 32'h0);
        check("reset_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // IF-first arbitration on the MEM_FIRST = 0 instance (RAMs still identical).
        both_b(32'h0000_0345, 2'b11, 32'h0000_1000);
        both_b(32'h0000_0077, 2'b00, 32'h0001_FFFE);

        // Directed scenarios
        txn(1'b1, 1'b1, 2'b11, 32'h0000_0100, 32'h4433_2211);
        txn(1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0);
        txn(1'b1, 1'b1, 2'b01, 32'h0000_0002, 32'h1234_BEEF);
        txn(1'b1, 1'b1, 2'b00, 32'h0000_0007, 32'h0000_0080);
        txn(1'b1, 1'b0, 2'b00, 32'h0000_0007, 32'h0);
        check("byte_load_value", mem_rdata, 32'h0000_0080);
        check("if_word_value", if_data, 32'h4433_2211);
        txn(1'b1, 1'b0, 2'b11, 32'h0001_FFFE, 32'h0);
        txn(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0);
        txn(1'b1, 1'b0, 2'b01, 32'h0000_0002, 32'h0);
        check("half_load_value", mem_rdata, 32'h0000_BEEF);
        both_a(32'h0000_0200, 1'b1, 2'b11, 32'hCAFE_F00D, 32'h0000_0200);
        both_a(32'h0000_0300, 1'b0, 2'b01, 32'h0, 32'h0000_0400);

        reset_mid_store(32'h0000_0500, 32'hA1B2_C3D4);
        txn(1'b0, 1'b0, 2'b11, 32'h0000_0500, 32'h0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            bit is_mem, we;
            logic [31:0] addr;
            is_mem = 1'($urandom);
            we     = 1'($urandom);
            addr   = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h0001_FFFC) : $urandom;
            txn(is_mem, we, 2'($urandom), addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
